// File: rtl/stream_max_argmax.sv
// stream_max_argmax: frame-wide streaming max/min with global {beat, lane} index
module stream_max_argmax #(
  parameter int WIDTH  = 8,
  parameter int SIZE   = 2,
  parameter int BEAT_W = 4,
  parameter bit SIGNED = 1'b0
)(
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [(2**SIZE)*WIDTH-1:0]     in_data,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic                           in_last,
  input  logic                           in_mode,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [WIDTH-1:0]               out_data,
  output logic [BEAT_W+SIZE-1:0]         out_index,
  output logic                           out_overflow
);
  localparam int LANES = 2**SIZE;
  localparam int IW    = BEAT_W + SIZE;
  localparam int NODES = 2*LANES - 1;
  localparam logic [BEAT_W-1:0] BEAT_MAX = '1;

  // Tree nodes are stored level by level: level 0 is the input stage, the root is NODES-1.
  logic [WIDTH-1:0]  r_tv [NODES];
  logic [IW-1:0]     r_ti [NODES];
  logic [SIZE:0]     r_lv, r_ll, r_lm, r_lo;
  logic              r_first, r_mode, r_sat;
  logic [BEAT_W-1:0] r_beat_cnt;
  logic              r_acc_first, r_bo;
  logic [WIDTH-1:0]  r_bv;
  logic [IW-1:0]     r_bi;
  logic              r_out_valid, r_out_ovf;
  logic [WIDTH-1:0]  r_out_data;
  logic [IW-1:0]     r_out_index;
  logic              w_en, w_acc, w_eff_mode, w_pick, w_done, w_bo;
  logic [WIDTH-1:0]  w_bv;
  logic [IW-1:0]     w_bi;

  function automatic logic pick_b(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                  input logic mode);
    logic gt, lt;
    gt = SIGNED ? ($signed(b) > $signed(a)) : (b > a);
    lt = SIGNED ? ($signed(b) < $signed(a)) : (b < a);
    return mode ? lt : gt;
  endfunction

  function automatic int off(input int l);
    return 2*LANES - ((2*LANES) >> l);
  endfunction

  assign w_en       = !(r_out_valid && !out_ready);
  assign w_acc      = in_valid && w_en;
  assign w_eff_mode = r_first ? in_mode : r_mode;
  assign w_pick     = r_acc_first || pick_b(r_bv, r_tv[NODES-1], r_lm[SIZE]);
  assign w_bv       = w_pick ? r_tv[NODES-1] : r_bv;
  assign w_bi       = w_pick ? r_ti[NODES-1] : r_bi;
  assign w_bo       = r_lo[SIZE] | (!r_acc_first & r_bo);
  assign w_done     = r_lv[SIZE] && r_ll[SIZE];

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_first     <= 1'b1;
      r_mode      <= 1'b0;
      r_sat       <= 1'b0;
      r_beat_cnt  <= '0;
      r_lv        <= '0;
      r_ll        <= '0;
      r_lm        <= '0;
      r_lo        <= '0;
      for (int n = 0; n < NODES; n++) begin
        r_tv[n] <= '0;
        r_ti[n] <= '0;
      end
      r_acc_first <= 1'b1;
      r_bv        <= '0;
      r_bi        <= '0;
      r_bo        <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_index <= '0;
      r_out_ovf   <= 1'b0;
    end else if (w_en) begin
      if (w_acc) begin
        r_first    <= in_last;
        r_mode     <= w_eff_mode;
        r_beat_cnt <= in_last ? '0 : (r_beat_cnt == BEAT_MAX) ? r_beat_cnt : r_beat_cnt + 1'b1;
        r_sat      <= in_last ? 1'b0 : (r_sat | (r_beat_cnt == BEAT_MAX));
      end
      r_lv[0] <= w_acc;
      r_ll[0] <= in_last;
      r_lm[0] <= w_eff_mode;
      r_lo[0] <= r_sat;
      for (int k = 0; k < LANES; k++) begin
        r_tv[k] <= in_data[WIDTH*k +: WIDTH];
        r_ti[k] <= {r_beat_cnt, SIZE'(k)};
      end
      for (int l = 0; l < SIZE; l++) begin
        r_lv[l+1] <= r_lv[l];
        r_ll[l+1] <= r_ll[l];
        r_lm[l+1] <= r_lm[l];
        r_lo[l+1] <= r_lo[l];
        for (int k = 0; k < (LANES >> (l+1)); k++) begin
          r_tv[off(l+1)+k] <= pick_b(r_tv[off(l)+2*k], r_tv[off(l)+2*k+1], r_lm[l]) ?
                              r_tv[off(l)+2*k+1] : r_tv[off(l)+2*k];
          r_ti[off(l+1)+k] <= pick_b(r_tv[off(l)+2*k], r_tv[off(l)+2*k+1], r_lm[l]) ?
                              r_ti[off(l)+2*k+1] : r_ti[off(l)+2*k];
        end
      end
      if (r_lv[SIZE]) begin
        r_acc_first <= r_ll[SIZE];
        r_bv        <= w_bv;
        r_bi        <= w_bi;
        r_bo        <= w_bo;
      end
      r_out_valid <= w_done;
      if (w_done) begin
        r_out_data  <= w_bv;
        r_out_index <= w_bi;
        r_out_ovf   <= w_bo;
      end
    end

  assign in_ready     = w_en;
  assign out_valid    = r_out_valid;
  assign out_data     = r_out_data;
  assign out_index    = r_out_index;
  assign out_overflow = r_out_ovf;
endmodule

// File: tb/tb_stream_max_argmax.sv
// tb_stream_max_argmax: directed checks of stream_max_argmax (unsigned and signed instances)
module tb_stream_max_argmax;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] in_data;
  logic        in_valid, in_ready, in_last, in_mode;
  logic        out_valid, out_ready, out_overflow;
  logic [7:0]  out_data;
  logic [3:0]  out_index;
  logic [31:0] s_data;
  logic        s_valid, s_ready, s_last, s_mode;
  logic        s_out_valid, s_out_ready, s_out_overflow;
  logic [7:0]  s_out_data;
  logic [3:0]  s_out_index;
  int          tests = 0;
  int          fails = 0;
  int          n;

  always #5 clk = ~clk;

  stream_max_argmax #(.WIDTH(8), .SIZE(2), .BEAT_W(2), .SIGNED(1'b0)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .in_mode(in_mode), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_index(out_index), .out_overflow(out_overflow));

  stream_max_argmax #(.WIDTH(8), .SIZE(2), .BEAT_W(2), .SIGNED(1'b1)) u_sdut (
    .clk(clk), .rst_n(rst_n), .in_data(s_data), .in_valid(s_valid), .in_ready(s_ready),
    .in_last(s_last), .in_mode(s_mode), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_data(s_out_data), .out_index(s_out_index), .out_overflow(s_out_overflow));

  function automatic logic [31:0] pk(input logic [7:0] a, input logic [7:0] b,
                                     input logic [7:0] c, input logic [7:0] d);
    return {d, c, b, a};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [7:0] d, input logic [3:0] idx,
                         input logic ovf);
    chk({tag, ".valid"}, out_valid, 1);
    chk({tag, ".data"}, out_data, d);
    chk({tag, ".index"}, out_index, idx);
    chk({tag, ".ovf"}, out_overflow, ovf);
  endtask

  task automatic send(input logic [31:0] d, input logic last, input logic mode);
    logic rdy;
    rdy = 1'b0;
    in_data = d; in_last = last; in_mode = mode; in_valid = 1'b1;
    for (int t = 0; t < 40; t++) begin
      rdy = in_ready;
      @(posedge clk); #1;
      if (rdy) break;
    end
    chk("accept", rdy, 1);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int cnt);
    cnt = 0;
    while (!out_valid && cnt < 30) begin
      @(posedge clk); #1;
      cnt++;
    end
  endtask

  task automatic consume;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    in_valid = 0; in_data = 0; in_last = 0; in_mode = 0; out_ready = 1;
    s_valid = 0; s_data = 0; s_last = 0; s_mode = 0; s_out_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.valid", out_valid, 0);
    chk("rst.data", out_data, 0);
    chk("rst.index", out_index, 0);
    chk("rst.ovf", out_overflow, 0);
    chk("rst.in_ready", in_ready, 1);
    rst_n = 1;
    consume();
    // single beat, tie goes to lane 1 over lane 3
    send(pk(3, 9, 5, 9), 1, 0);
    wait_out(n);
    chk("t1.latency", n, 3);
    chk_out("t1", 9, 1, 0);
    // three-beat max frame
    send(pk(1, 2, 3, 4), 0, 0);
    send(pk(7, 0, 0, 0), 0, 0);
    send(pk(7, 6, 5, 4), 1, 0);
    wait_out(n);
    chk("t2.latency", n, 3);
    chk_out("t2", 7, 4, 0);
    // min mode latched from first beat
    send(pk(10, 2, 2, 8), 0, 1);
    send(pk(5, 5, 5, 5), 1, 0);
    wait_out(n);
    chk_out("t3", 2, 1, 0);
    consume();
    // backpressure with a second and third frame behind
    out_ready = 0;
    send(pk(1, 50, 3, 4), 1, 0);
    send(pk(9, 9, 60, 9), 0, 0);
    send(pk(0, 0, 0, 0), 1, 0);
    wait_out(n);
    chk_out("t4a", 50, 1, 0);
    in_data = pk(0, 0, 0, 77); in_last = 1; in_mode = 0; in_valid = 1;
    for (int i = 0; i < 5; i++) begin
      consume();
      chk("t4.stall_ready", in_ready, 0);
      chk("t4.hold_valid", out_valid, 1);
      chk("t4.hold_data", out_data, 50);
      chk("t4.hold_index", out_index, 1);
    end
    out_ready = 1;
    consume();
    in_valid = 0;
    chk("t4.no_dup", out_valid, 0);
    wait_out(n);
    chk_out("t4b", 60, 2, 0);
    consume();
    wait_out(n);
    chk_out("t4c", 77, 3, 0);
    consume();
    send(pk(1, 2, 3, 4), 1, 0);
    send(pk(8, 1, 1, 1), 1, 0);
    wait_out(n);
    chk_out("t4d", 4, 3, 0);
    consume();
    chk_out("t4e", 8, 0, 0);
    consume();
    // overflow: fifth beat reuses the saturated beat number 3
    for (int i = 0; i < 4; i++) send(pk(0, 0, 0, 0), 0, 0);
    send(pk(0, 0, 200, 0), 1, 0);
    wait_out(n);
    chk_out("t5", 200, 14, 1);
    consume();
    send(pk(5, 1, 1, 1), 1, 0);
    wait_out(n);
    chk_out("t5.next", 5, 0, 0);
    consume();
    // signed instance, max then min
    chk("t6.s_ready", s_ready, 1);
    s_data = pk(8'h80, 8'h7F, 8'hFF, 8'h01); s_last = 1; s_mode = 0; s_valid = 1;
    consume();
    s_valid = 0;
    n = 0;
    while (!s_out_valid && n < 30) begin consume(); n++; end
    chk("t6.s_latency", n, 3);
    chk("t6.s_max_data", s_out_data, 8'h7F);
    chk("t6.s_max_index", s_out_index, 1);
    s_data = pk(8'h05, 8'h80, 8'hFF, 8'h80); s_mode = 1; s_valid = 1;
    consume();
    s_valid = 0;
    n = 0;
    while (!s_out_valid && n < 30) begin consume(); n++; end
    chk("t6.s_min_valid", s_out_valid, 1);
    chk("t6.s_min_data", s_out_data, 8'h80);
    chk("t6.s_min_index", s_out_index, 1);
    // asynchronous reset with a partial frame in flight
    send(pk(1, 2, 3, 99), 1, 0);
    send(pk(0, 0, 0, 250), 0, 0);
    send(pk(0, 0, 0, 251), 0, 0);
    consume();
    chk_out("t6.pre", 99, 3, 0);
    #2 rst_n = 0;
    #1;
    chk("t6.rst_valid", out_valid, 0);
    chk("t6.rst_data", out_data, 0);
    chk("t6.rst_index", out_index, 0);
    chk("t6.rst_ovf", out_overflow, 0);
    @(posedge clk); #1;
    rst_n = 1;
    send(pk(4, 3, 2, 6), 1, 1);
    wait_out(n);
    chk("t6.post_latency", n, 3);
    chk_out("t6.post", 2, 2, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
